// File: rtl/dtree_pkg.sv
// Shared types and sizing helpers for the decision-tree feature loader.
package dtree_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_SETTLE = 2'd2,
        S_HOLD   = 2'd3
    } dtree_state_e;

    localparam int N_FEAT_DEF  = 16;
    localparam int FEAT_W_DEF  = 8;
    localparam int CLASS_W_DEF = 4;
    localparam int SETTLE_DEF  = 2;
    localparam int FRAME_BITS  = N_FEAT_DEF * FEAT_W_DEF;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dtree_sipo.sv
// Left-shifting serial-in/parallel-out register; clear may accompany a shift
// so a new frame's first bit lands in an otherwise empty register.
module dtree_sipo #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_i,
    input  logic         clr_i,
    input  logic         din_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] base;

    assign base = clr_i ? '0 : q_q;

    always_ff @(posedge clk) begin
        if (rst)          q_q <= '0;
        else if (shift_i) q_q <= {base[W-2:0], din_i};
        else if (clr_i)   q_q <= '0;
    end

    assign q_o = q_q;

endmodule

// File: rtl/dtree_feature_loader.sv
// Bit-serial frame deserialiser feeding a combinational decision tree, with
// class capture and valid/ready output. DTREE_LOADER_PARITY_EN adds a trailing parity bit.
module dtree_feature_loader
    import dtree_pkg::*;
#(
    parameter int N_FEAT  = N_FEAT_DEF,
    parameter int FEAT_W  = FEAT_W_DEF,
    parameter int CLASS_W = CLASS_W_DEF,
    parameter int SETTLE  = SETTLE_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic                       sdi,
    input  logic                       sdi_valid,
    output logic [N_FEAT*FEAT_W-1:0]   feat_out,
    input  logic [CLASS_W-1:0]         class_in,
    output logic [CLASS_W-1:0]         out_class,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       err_overrun
`ifdef DTREE_LOADER_PARITY_EN
    ,
    output logic                       err_parity
`endif
);

    localparam int FB = N_FEAT * FEAT_W;
`ifdef DTREE_LOADER_PARITY_EN
    localparam int LEN = FB + 1;
`else
    localparam int LEN = FB;
`endif
    localparam int BCW = cnt_w(LEN);
    localparam int SCW = cnt_w(SETTLE);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(LEN - 1);
    localparam logic [SCW-1:0] LAST_SET = SCW'(SETTLE - 1);

    dtree_state_e       state_q, state_d;
    logic [BCW-1:0]     bit_cnt_q;
    logic [SCW-1:0]     set_cnt_q;
    logic [CLASS_W-1:0] out_class_q;
    logic               out_valid_q, err_ovr_q;
    logic               shift_en, sr_clr, par_bad, par_bit;
    logic [FB-1:0]      sr;

    wire start    = sdi_valid & frame_start;
    wire last_bit = (bit_cnt_q == LAST_BIT);
    wire capture  = (state_q == S_SETTLE) && (set_cnt_q == LAST_SET);

`ifdef DTREE_LOADER_PARITY_EN
    logic par_q, err_par_q;
    assign par_bit = (bit_cnt_q == BCW'(FB));
    assign par_bad = par_q ^ sdi;
    assign err_parity = err_par_q;
`else
    assign par_bit = 1'b0;
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_SHIFT;
            S_SHIFT:  if (sdi_valid && !frame_start && last_bit)
                          state_d = (par_bit && par_bad) ? S_IDLE : S_SETTLE;
            S_SETTLE: if (capture) state_d = S_HOLD;
            S_HOLD:   if (out_valid_q && out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shift_en = 1'b0;
        sr_clr   = 1'b0;
        busy     = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                shift_en = start;
                sr_clr   = start;
            end
            S_SHIFT: begin
                shift_en = sdi_valid && (frame_start || !par_bit);
                sr_clr   = start;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            set_cnt_q   <= '0;
            out_class_q <= '0;
            out_valid_q <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            if (start && (state_q == S_IDLE || state_q == S_SHIFT))
                bit_cnt_q <= BCW'(1);
            else if (state_q == S_SHIFT && sdi_valid)
                bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;

            set_cnt_q <= (state_q == S_SETTLE && !capture) ? set_cnt_q + 1'b1 : '0;

            if (capture) begin
                out_class_q <= class_in;
                out_valid_q <= 1'b1;
            end else if (state_q == S_HOLD && out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (sdi_valid && (state_q == S_SETTLE || state_q == S_HOLD))
                err_ovr_q <= 1'b1;
        end
    end

`ifdef DTREE_LOADER_PARITY_EN
    // Running even parity over feature bits; restarted by any accepted frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q     <= 1'b0;
            err_par_q <= 1'b0;
        end else begin
            if (shift_en) par_q <= sr_clr ? sdi : (par_q ^ sdi);
            if (state_q == S_SHIFT && sdi_valid && !frame_start && par_bit && par_bad)
                err_par_q <= 1'b1;
        end
    end
`endif

    dtree_sipo #(.W(FB)) u_sipo (
        .clk     (clk),
        .rst     (rst),
        .shift_i (shift_en),
        .clr_i   (sr_clr),
        .din_i   (sdi),
        .q_o     (sr)
    );

    // First received feature sits at the top of the shift register but at the bottom of the bus.
    for (genvar k = 0; k < N_FEAT; k++) begin : g_map
        assign feat_out[k*FEAT_W +: FEAT_W] = sr[(N_FEAT-1-k)*FEAT_W +: FEAT_W];
    end

    assign out_class   = out_class_q;
    assign out_valid   = out_valid_q;
    assign err_overrun = err_ovr_q;

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Randomised self-checking bench for dtree_feature_loader against a frame-level reference model.
module tb_dtree_feature_loader;

    localparam int N_FEAT = 16;
    localparam int FEAT_W = 8;
    localparam int SETTLE = 2;
    localparam int FB     = N_FEAT * FEAT_W;

    logic          clk = 1'b0;
    logic          rst, frame_start, sdi, sdi_valid, out_ready;
    logic [FB-1:0] feat_out;
    logic [3:0]    class_in, out_class;
    logic          out_valid, busy, err_overrun;
`ifdef DTREE_LOADER_PARITY_EN
    logic          err_parity;
`endif

    always #5 clk = ~clk;

    // Tree stub: mixes feature 0 and feature 15 so bus ordering matters.
    assign class_in = feat_out[7:4] ^ feat_out[FB-1 -: 4];

    dtree_feature_loader #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLASS_W(4), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .sdi(sdi), .sdi_valid(sdi_valid),
        .feat_out(feat_out), .class_in(class_in), .out_class(out_class), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .err_overrun(err_overrun)
`ifdef DTREE_LOADER_PARITY_EN
        , .err_parity(err_parity)
`endif
    );

    int n_cmp = 0, n_bad = 0;
    logic [7:0] feat [N_FEAT];

    task automatic chk(input string tag, input logic [FB-1:0] got, input logic [FB-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FB-1:0] exp_bus();
        logic [FB-1:0] b;
        for (int k = 0; k < N_FEAT; k++) b[k*FEAT_W +: FEAT_W] = feat[k];
        return b;
    endfunction

    function automatic logic [3:0] exp_cls();
        return feat[0][7:4] ^ feat[N_FEAT-1][7:4];
    endfunction

    // Stream order: feature 0 first, each feature MSB first.
    function automatic logic stream_bit(input int i);
        logic [7:0] f;
        f = feat[i / FEAT_W];
        return f[FEAT_W - 1 - (i % FEAT_W)];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        sdi_valid = 1'b0; frame_start = 1'b0; sdi = 1'b0;
    endtask

    task automatic rand_feats();
        for (int k = 0; k < N_FEAT; k++) feat[k] = 8'($urandom);
    endtask

    task automatic send_bits(input int from, input int to, input bit gaps);
        for (int i = from; i < to; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    sdi_valid = 1'b0; frame_start = 1'($urandom); sdi = 1'($urandom);
                    out_ready = 1'($urandom);
                    tick();
                end
            end
            sdi_valid = 1'b1; frame_start = (i == 0); sdi = stream_bit(i);
            tick();
        end
        idle_in();
        out_ready = 1'b0;
    endtask

    task automatic send_par(input bit flip);
        sdi_valid = 1'b1; frame_start = 1'b0; sdi = (^exp_bus()) ^ flip;
        tick();
        idle_in();
    endtask

    // Finish the current frame, optionally injecting one overrun bit in SETTLE, and check delivery.
    task automatic finish_frame(input bit ovr);
        int lat;
`ifdef DTREE_LOADER_PARITY_EN
        send_par(1'b0);
`endif
        lat = 0;
        if (ovr) begin
            sdi_valid = 1'b1; frame_start = 1'b1; sdi = 1'($urandom);
            tick();
            idle_in();
            lat = 1;
        end
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", FB'(lat), FB'(SETTLE));
        chk("out_valid", FB'(out_valid), FB'(1));
        chk("out_class", FB'(out_class), FB'(exp_cls()));
        chk("feat_out", feat_out, exp_bus());
        chk("busy_hold", FB'(busy), FB'(1));
    endtask

    task automatic handshake(input int delay);
        logic [3:0] c;
        c = exp_cls();
        out_ready = 1'b0;
        repeat (delay) begin
            tick();
            chk("hold_class", FB'(out_class), FB'(c));
            chk("hold_valid", FB'(out_valid), FB'(1));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_valid", FB'(out_valid), FB'(0));
        chk("hs_idle", FB'(busy), FB'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_feat"}, feat_out, '0);
        chk({tag, "_cls"}, FB'(out_class), '0);
        chk({tag, "_vld"}, FB'(out_valid), '0);
        chk({tag, "_busy"}, FB'(busy), '0);
        chk({tag, "_ovr"}, FB'(err_overrun), '0);
`ifdef DTREE_LOADER_PARITY_EN
        chk({tag, "_par"}, FB'(err_parity), '0);
`endif
    endtask

    initial begin
        bit seen;
        rst = 1'b1; out_ready = 1'b0;
        idle_in();
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        // Stray bits in IDLE without frame_start are ignored.
        repeat (5) begin
            sdi_valid = 1'b1; frame_start = 1'b0; sdi = 1'($urandom);
            tick();
        end
        idle_in();
        chk("stray_busy", FB'(busy), '0);
        chk("stray_ovr", FB'(err_overrun), '0);

        // Directed: feature 0 = 0x5A, the rest zero.
        foreach (feat[k]) feat[k] = 8'h00;
        feat[0] = 8'h5A;
        send_bits(0, FB, 1'b0);
        finish_frame(1'b0);
        chk("dir_cls", FB'(out_class), FB'(4'h5));
        chk("dir_f0", FB'(feat_out[7:0]), FB'(8'h5A));
        handshake(10);

        for (int f = 0; f < 6; f++) begin
            rand_feats();
            send_bits(0, FB, 1'b1);
            finish_frame(1'b0);
            handshake($urandom_range(0, 4));
        end

        // Abort: 40 bits of one frame, then a complete new frame.
        rand_feats();
        send_bits(0, 40, 1'b1);
        rand_feats();
        seen = 1'b0;
        for (int i = 0; i < FB; i++) begin
            sdi_valid = 1'b1; frame_start = (i == 0); sdi = stream_bit(i);
            tick();
            if (out_valid) seen = 1'b1;
        end
        idle_in();
        chk("abort_early", FB'(seen), '0);
        chk("abort_ovr", FB'(err_overrun), '0);
        finish_frame(1'b0);
        handshake(1);

        // Overrun during SETTLE.
        rand_feats();
        send_bits(0, FB, 1'b1);
        finish_frame(1'b1);
        chk("ovr_set", FB'(err_overrun), FB'(1));
        handshake(2);
        chk("ovr_sticky", FB'(err_overrun), FB'(1));

        // Reset in SHIFT at bit 70.
        rand_feats();
        send_bits(0, 70, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("rst_shift");
        rand_feats();
        send_bits(0, FB, 1'b1);
        finish_frame(1'b0);
        handshake(1);

        // Reset in HOLD.
        rand_feats();
        send_bits(0, FB, 1'b0);
        finish_frame(1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("rst_hold");
        rand_feats();
        send_bits(0, FB, 1'b1);
        finish_frame(1'b0);
        handshake(0);

`ifdef DTREE_LOADER_PARITY_EN
        rand_feats();
        send_bits(0, FB, 1'b0);
        send_par(1'b1);
        chk("par_idle", FB'(busy), '0);
        chk("par_err", FB'(err_parity), FB'(1));
        seen = 1'b0;
        repeat (SETTLE + 3) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("par_novalid", FB'(seen), '0);
        rand_feats();
        send_bits(0, FB, 1'b1);
        finish_frame(1'b0);
        handshake(1);
        chk("par_sticky", FB'(err_parity), FB'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
